mem_access_unit: RTL and testbench

//  Load/store front end between execute stage and DataMemory. Accepts one request via valid/ready,

---
 rtl/mem_access_unit_if.sv | 47 ++++
 rtl/mem_access_unit.sv | 91 +++++++++
 tb/tb_mem_access_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request, DataMemory and response signals of the load/store front end
`ifndef STORE_BYTE
`define STORE_BYTE 4'd1
`endif
`ifndef STORE_HALFWORD
`define STORE_HALFWORD 4'd2
`endif
`ifndef STORE_WORD
`define STORE_WORD 4'd4
`endif
`ifndef STORE_DOUBLEWORD
`define STORE_DOUBLEWORD 4'd8
`endif
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        MemReadEn;
  logic        MemWriteEn;
  logic [3:0]  storetype;
  logic [63:0] AddressBus;
  logic [63:0] DataMemoryInput;
  logic [63:0] DataMemoryOutput;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_is_load;
  logic [4:0]  rsp_rd;
  logic [63:0] rsp_data;
  logic        rsp_fault;
  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output DataMemoryOutput, rsp_ready,
    input  req_ready, MemReadEn, MemWriteEn, storetype, AddressBus, DataMemoryInput,
    input  rsp_valid, rsp_is_load, rsp_rd, rsp_data, rsp_fault
  );
  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  DataMemoryOutput, rsp_ready,
    output req_ready, MemReadEn, MemWriteEn, storetype, AddressBus, DataMemoryInput,
    output rsp_valid, rsp_is_load, rsp_rd, rsp_data, rsp_fault
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end to DataMemory; define MISALIGN_TRAP_EN to fault misaligned accesses
module mem_access_unit #(
  parameter int unsigned     DM_BITS = 8,
  parameter longint unsigned DM_SIZE = 64'd1 << DM_BITS
) (
  input logic              clock,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [64:0] LIMIT = {1'b0, 64'(DM_SIZE)};
  state_t      state_q, state_d;
  logic        is_load_q, fault_q, fault_d, misalign, accept;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [63:0] addr_q, wdata_q, data_q, ext;
  logic [64:0] size, end_a;
  // classify the incoming request: opcode legality, range (65-bit, no wrap) and optional alignment
  always_comb begin
    size = 65'd1 << bus.req_funct3[1:0];
    end_a = {1'b0, bus.req_addr} + size;
`ifdef MISALIGN_TRAP_EN
    misalign = |(bus.req_addr[2:0] & (size[2:0] - 3'd1));
`else
    misalign = 1'b0;
`endif
    fault_d = (bus.req_is_load == bus.req_is_store) | (bus.req_is_load & (bus.req_funct3 == 3'd7)) |
              (bus.req_is_store & bus.req_funct3[2]) | ({1'b0, bus.req_addr} >= LIMIT) |
              (end_a > LIMIT) | misalign;
  end
  // extend the registered DataMemory read according to the captured funct3
  always_comb begin
    ext = bus.DataMemoryOutput;
    ext = f3_q == 3'd0 ? {{56{ext[7]}}, ext[7:0]} :
          f3_q == 3'd1 ? {{48{ext[15]}}, ext[15:0]} :
          f3_q == 3'd2 ? {{32{ext[31]}}, ext[31:0]} :
          f3_q == 3'd4 ? {56'd0, ext[7:0]} :
          f3_q == 3'd5 ? {48'd0, ext[15:0]} :
          f3_q == 3'd6 ? {32'd0, ext[31:0]} : ext;
  end
  // next state: faults skip straight to the response, stores skip the read wait
  always_comb begin
    state_d = state_q;
    accept = (state_q == IDLE) & bus.req_valid;
    case (state_q)
      IDLE:    state_d = bus.req_valid ? (fault_d ? RESP : ISSUE) : IDLE;
      ISSUE:   state_d = is_load_q ? WAIT : RESP;
      WAIT:    state_d = RESP;
      default: state_d = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  // state and request capture; response data cleared on accept and loaded as WAIT exits
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      is_load_q <= 1'b0;
      fault_q <= 1'b0;
      f3_q <= 3'd0;
      rd_q <= 5'd0;
      addr_q <= 64'd0;
      wdata_q <= 64'd0;
      data_q <= 64'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_load_q <= bus.req_is_load;
        fault_q <= fault_d;
        f3_q <= bus.req_funct3;
        rd_q <= bus.req_rd;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        data_q <= 64'd0;
      end
      if (state_q == WAIT) data_q <= ext;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.MemReadEn = (state_q == ISSUE) & is_load_q;
  assign bus.MemWriteEn = (state_q == ISSUE) & ~is_load_q;
  assign bus.AddressBus = state_q == ISSUE ? addr_q : 64'd0;
  assign bus.DataMemoryInput = state_q == ISSUE ? wdata_q : 64'd0;
  assign bus.storetype = state_q != ISSUE ? 4'd0 :
                         f3_q[1:0] == 2'd0 ? `STORE_BYTE :
                         f3_q[1:0] == 2'd1 ? `STORE_HALFWORD :
                         f3_q[1:0] == 2'd2 ? `STORE_WORD : `STORE_DOUBLEWORD;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_is_load = is_load_q;
  assign bus.rsp_rd = rd_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_fault = fault_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte-addressed DataMemory model
module tb_mem_access_unit;
  localparam int DM = 256;
  typedef struct {
    logic        ld;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        fault;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_access_unit_if bus();
  mem_access_unit #(.DM_BITS(8), .DM_SIZE(DM)) dut (.clock(clk), .rst(rst), .bus(bus));
  logic [7:0] dm [DM];
  logic [7:0] shadow [DM];
  logic inited = 1'b0;
  int en_cnt = 0;
  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  // DataMemory model: byte writes per storetype, registered 8-byte little-endian read
  always @(posedge clk) begin
    logic [63:0] tmp;
    int nb;
    if (!inited) begin
      for (int i = 0; i < DM; i++) dm[i] <= i < 16 ? 8'(i) : (i < 24 ? 8'(8'h80 + i - 16) : 8'h00);
      inited <= 1'b1;
    end
    if (bus.MemReadEn || bus.MemWriteEn) en_cnt++;
    if (bus.MemWriteEn) begin
      nb = bus.storetype == `STORE_BYTE ? 1 : bus.storetype == `STORE_HALFWORD ? 2 :
           bus.storetype == `STORE_WORD ? 4 : bus.storetype == `STORE_DOUBLEWORD ? 8 : 0;
      for (int i = 0; i < 8; i++)
        if (i < nb && bus.AddressBus + 64'(i) < 64'(DM)) dm[bus.AddressBus + 64'(i)] <= bus.DataMemoryInput[8*i +: 8];
    end
    if (bus.MemReadEn) begin
      for (int i = 0; i < 8; i++)
        tmp[8*i +: 8] = bus.AddressBus + 64'(i) < 64'(DM) ? dm[bus.AddressBus + 64'(i)] : 8'h00;
      bus.DataMemoryOutput <= tmp;
    end
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic ref_fault(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] a);
    logic [64:0] sz;
    logic bad;
    sz = 65'd1 << f3[1:0];
    bad = (ld == st) || (ld && f3 == 3'd7) || (st && f3 > 3'd3) || a >= 64'(DM) || ({1'b0, a} + sz) > 65'(DM);
`ifdef MISALIGN_TRAP_EN
    bad = bad || (a % sz[63:0]) != 64'd0;
`endif
    return bad;
  endfunction
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
    logic [63:0] raw;
    raw = 64'd0;
    for (int i = 0; i < (1 << f3[1:0]); i++) raw[8*i +: 8] = shadow[a + 64'(i)];
    case (f3)
      3'd0: return 64'($signed(raw[7:0]));
      3'd1: return 64'($signed(raw[15:0]));
      3'd2: return 64'($signed(raw[31:0]));
      default: return raw;
    endcase
  endfunction
  task automatic run(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] wd, input logic [4:0] rd, input int hold);
    exp_t e;
    int n, en0;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready", 64'(bus.req_ready), 64'd1);
    e.ld = ld;
    e.rd = rd;
    e.fault = ref_fault(ld, st, f3, a);
    e.data = (ld && !e.fault) ? ref_load(f3, a) : 64'd0;
    e.lat = e.fault ? 1 : (ld ? 3 : 2);
    if (st && !e.fault) for (int i = 0; i < (1 << f3[1:0]); i++) shadow[a + 64'(i)] = wd[8*i +: 8];
    sb.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_is_load = ld;
    bus.req_is_store = st;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    bus.req_rd = rd;
    bus.rsp_ready = hold == 0;
    en0 = en_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    check("latency", 64'(n), 64'(e.lat));
    check("rsp_is_load", 64'(bus.rsp_is_load), 64'(e.ld));
    check("rsp_rd", 64'(bus.rsp_rd), 64'(e.rd));
    check("rsp_data", bus.rsp_data, e.data);
    check("rsp_fault", 64'(bus.rsp_fault), 64'(e.fault));
    if (e.fault) check("mem_en_on_fault", 64'(en_cnt - en0), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_data", bus.rsp_data, e.data);
      check("hold_rd", 64'(bus.rsp_rd), 64'(e.rd));
      check("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_done", 64'(bus.rsp_valid), 64'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < DM; i++) shadow[i] = i < 16 ? 8'(i) : (i < 24 ? 8'(8'h80 + i - 16) : 8'h00);
    bus.req_valid = 1'b0;
    bus.req_is_load = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0;
    bus.req_rd = 5'd0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_mem_en", {62'd0, bus.MemReadEn, bus.MemWriteEn}, 64'd0);
    run(1, 0, 3'd0, 64'd16, 64'd0, 5'd5, 0);
    run(0, 1, 3'd3, 64'd8, 64'h1122334455667788, 5'd0, 0);
    run(1, 0, 3'd3, 64'd8, 64'd0, 5'd6, 0);
    run(1, 0, 3'd6, 64'd8, 64'd0, 5'd7, 0);
    run(1, 0, 3'd1, 64'd8, 64'd0, 5'd8, 0);
    run(1, 0, 3'd4, 64'd17, 64'd0, 5'd9, 0);
    run(1, 0, 3'd2, 64'd20, 64'd0, 5'd10, 0);
    run(0, 1, 3'd1, 64'd32, 64'h0000_0000_0000_BEEF, 5'd0, 0);
    run(1, 0, 3'd1, 64'd32, 64'd0, 5'd11, 0);
    run(1, 0, 3'd5, 64'd32, 64'd0, 5'd12, 0);
    run(1, 0, 3'd3, 64'(DM - 4), 64'd0, 5'd13, 0);
    run(1, 0, 3'd3, 64'(DM - 8), 64'd0, 5'd14, 0);
    run(1, 0, 3'd0, 64'(DM - 1), 64'd0, 5'd15, 0);
    run(1, 0, 3'd0, 64'(DM), 64'd0, 5'd16, 0);
    run(1, 0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 5'd17, 0);
    run(1, 0, 3'd7, 64'd0, 64'd0, 5'd18, 0);
    run(0, 1, 3'd4, 64'd40, 64'hAA, 5'd0, 0);
    run(1, 1, 3'd0, 64'd40, 64'hAA, 5'd19, 0);
    run(0, 0, 3'd0, 64'd40, 64'hAA, 5'd20, 0);
    run(1, 0, 3'd2, 64'd2, 64'd0, 5'd21, 0);
    run(1, 0, 3'd3, 64'd8, 64'd0, 5'd22, 5);
    run(1, 0, 3'd0, 64'd16, 64'd0, 5'd23, 0);
    bus.req_valid = 1'b1;
    bus.req_is_load = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'd3;
    bus.req_addr = 64'd8;
    bus.req_rd = 5'd24;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("issue_read_en", 64'(bus.MemReadEn), 64'd1);
    @(posedge clk); #1;
    check("wait_read_en", 64'(bus.MemReadEn), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("wrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("wrst_req_ready", 64'(bus.req_ready), 64'd1);
    check("wrst_mem_en", {62'd0, bus.MemReadEn, bus.MemWriteEn}, 64'd0);
    check("wrst_addr", bus.AddressBus, 64'd0);
    check("wrst_wdata", bus.DataMemoryInput, 64'd0);
    check("wrst_storetype", 64'(bus.storetype), 64'd0);
    @(posedge clk); #1;
    check("wrst_no_stray_rsp", 64'(bus.rsp_valid), 64'd0);
    run(1, 0, 3'd0, 64'd16, 64'd0, 5'd25, 0);
    run(0, 1, 3'd0, 64'd48, 64'h5A, 5'd0, 0);
    run(1, 0, 3'd0, 64'd48, 64'd0, 5'd26, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
